// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the two-requester AES-128 scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_128_LATENCY = 21;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } sched_tag_t;

  typedef struct packed {
    req_id_t                id;
    logic [AES_BLOCK_W-1:0] data;
  } sched_rsp_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// Synchronous response FIFO of {id, data} entries with occupancy count.
module aes_sched_fifo
  import aes_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  sched_rsp_t                   push_data,
  input  logic                         pop,
  output sched_rsp_t                   pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sched_rsp_t    mem_q [DEPTH];
  sched_rsp_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    pop_data = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/aes_128_sched.sv
// Round-robin scheduler and credit-based flow control in front of the
// fully pipelined aes_128 core; results are tagged and buffered in order.
module aes_128_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned LATENCY = AES_128_LATENCY,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [AES_BLOCK_W-1:0] req0_state,
  input  logic [AES_BLOCK_W-1:0] req0_key,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [AES_BLOCK_W-1:0] req1_state,
  input  logic [AES_BLOCK_W-1:0] req1_key,
  output logic [AES_BLOCK_W-1:0] core_state,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_out,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [AES_BLOCK_W-1:0] rsp_data,
  output logic                   rsp_id,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  req_id_t       last_q, last_d;
  logic [CW-1:0] used_q, used_d;
  sched_tag_t    tag_q [LATENCY];
  sched_tag_t    tag_d [LATENCY];

  logic          gnt_valid;
  req_id_t       gnt_id;
  logic          credit_ok;
  logic          issue;
  logic          pop;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  sched_rsp_t    fifo_push_data;
  sched_rsp_t    fifo_pop_data;

  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    // With both valid the pointer decides; otherwise the lone requester wins.
    gnt_id    = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    credit_ok = (used_q < CW'(DEPTH));
    issue     = gnt_valid & credit_ok;

    req0_ready = issue & (gnt_id == 1'b0);
    req1_ready = issue & (gnt_id == 1'b1);

    core_state = '0;
    core_key   = '0;
    if (issue) begin
      core_state = gnt_id ? req1_state : req0_state;
      core_key   = gnt_id ? req1_key   : req0_key;
    end

    last_d = issue ? gnt_id : last_q;

    tag_d[0] = '{valid: issue, id: issue ? gnt_id : 1'b0};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    rsp_valid = ~fifo_empty;
    pop       = rsp_valid & rsp_ready;
    used_d    = used_q + CW'(issue) - CW'(pop);
    busy      = (used_q != '0);

    fifo_push_data = '{id: tag_q[LATENCY-1].id, data: core_out};
    rsp_data       = fifo_pop_data.data;
    rsp_id         = fifo_pop_data.id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      used_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      last_q <= last_d;
      used_q <= used_d;
      tag_q  <= tag_d;
    end
  end

  aes_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_q[LATENCY-1].valid),
    .push_data (fifo_push_data),
    .pop       (pop),
    .pop_data  (fifo_pop_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  credit_chk: assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= used_q);

endmodule

// File: tb/tb_aes_128_sched.sv
// Directed bench for aes_128_sched with a behavioural 21-stage core model.
module tb_aes_128_sched;
  import aes_sched_pkg::*;

  localparam int unsigned LAT = 21;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] S0 = 128'h0a000000_00000000_00000000_00000000;
  localparam logic [127:0] S1 = 128'h0b000000_00000000_00000000_00000000;
  localparam logic [127:0] K0 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] K1 = 128'hdeadbeef_00000000_cafef00d_11111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_state, req0_key, req1_state, req1_key;
  logic [127:0] core_state, core_key, core_out;
  logic rsp_valid, rsp_ready, rsp_id, busy;
  logic [127:0] rsp_data;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;

  always #5 clk = ~clk;

  aes_128_sched #(.LATENCY(LAT), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_state(req0_state), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_state(req1_state), .req1_key(req1_key),
    .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Stand-in for aes_128: knows the FIPS-197 vector, otherwise a cheap keyed mix.
  function automatic logic [127:0] ref_enc(input logic [127:0] s, input logic [127:0] k);
    if (s == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return s ^ {k[63:0], k[127:64]};
  endfunction

  logic [127:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= ref_enc(core_state, core_key);
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_out = cpipe[LAT-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((busy || rsp_valid) && k < 300) begin
      cyc();
      k++;
    end
    chk(tag, 128'(busy), 128'd0);
  endtask

  // Scoreboard: accepts and pops are both decided before the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        chk("rsp_expected", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) begin
          chk("rsp_data", rsp_data, exp_q[0].data);
          chk("rsp_id", 128'(rsp_id), 128'(exp_q[0].id));
          void'(exp_q.pop_front());
        end
      end
      if (req0_valid && req0_ready) exp_q.push_back('{id: 1'b0, data: ref_enc(req0_state, req0_key)});
      if (req1_valid && req1_ready) exp_q.push_back('{id: 1'b1, data: ref_enc(req1_state, req1_key)});
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout");
  end

  initial begin
    int i0 = 0;
    int i1 = 0;
    int n;
    int acc;
    int base;
    int k;
    logic early;
    logic exp_id;
    logic [127:0] pend;

    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_state = '0; req0_key = '0; req1_state = '0; req1_key = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_req0_ready", 128'(req0_ready), 128'd0);
    chk("rst_req1_ready", 128'(req1_ready), 128'd0);
    chk("rst_core_state", core_state, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    rst_n = 1;
    cyc();

    // FIPS-197 vector on req0
    req0_valid = 1; req0_state = FIPS_PT; req0_key = FIPS_KEY;
    #1;
    chk("fips_ready", 128'(req0_ready), 128'd1);
    chk("fips_req1_ready", 128'(req1_ready), 128'd0);
    chk("fips_core_state", core_state, FIPS_PT);
    chk("fips_core_key", core_key, FIPS_KEY);
    cyc();
    req0_valid = 0; req0_state = '0; req0_key = '0;
    #1;
    chk("fips_busy", 128'(busy), 128'd1);
    chk("idle_core_state", core_state, 128'd0);
    early = 0;
    for (int e = 1; e <= 20; e++) begin
      cyc();
      if (rsp_valid) early = 1;
    end
    chk("fips_no_early", 128'(early), 128'd0);
    cyc();
    chk("fips_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("fips_rsp_data", rsp_data, FIPS_CT);
    chk("fips_rsp_id", 128'(rsp_id), 128'd0);
    rsp_ready = 1;
    cyc();
    chk("fips_popped", 128'(rsp_valid), 128'd0);
    chk("fips_busy_done", 128'(busy), 128'd0);

    // Both valid: alternating grants; last grant was req0
    req0_valid = 1; req1_valid = 1; req0_key = K0; req1_key = K1;
    n = 0; exp_id = 1'b1;
    for (int c = 0; c < 200 && n < 8; c++) begin
      req0_state = S0 + 128'(i0); req1_state = S1 + 128'(i1);
      #1;
      if (req0_ready || req1_ready) begin
        chk("alt_onehot", 128'(req0_ready & req1_ready), 128'd0);
        chk("alt_grant", 128'(req1_ready), 128'(exp_id));
        if (req1_ready) i1++; else i0++;
        exp_id = ~exp_id;
        n++;
      end
      cyc();
    end
    chk("alt_count", 128'(n), 128'd8);
    req0_valid = 0; req1_valid = 0;
    wait_idle("alt_drain");
    chk("alt_sb_empty", 128'(exp_q.size()), 128'd0);

    // Backpressure: credit caps acceptance at DEPTH
    rsp_ready = 0; req0_valid = 1; req1_valid = 1;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      req0_state = S0 + 128'(i0); req1_state = S1 + 128'(i1);
      #1;
      if (req0_ready) begin acc++; i0++; end
      if (req1_ready) begin acc++; i1++; end
      cyc();
    end
    req0_state = S0 + 128'(i0); req1_state = S1 + 128'(i1);
    #1;
    chk("bp_accepts", 128'(acc), 128'd4);
    chk("bp_req0_ready", 128'(req0_ready), 128'd0);
    chk("bp_req1_ready", 128'(req1_ready), 128'd0);
    chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
    chk("bp_busy", 128'(busy), 128'd1);

    // Full credit: pop cycle sees pre-pop count
    req0_valid = 0; rsp_ready = 1;
    #1;
    chk("pop_cycle_ready", 128'(req1_ready), 128'd0);
    cyc();
    rsp_ready = 0;
    #1;
    chk("post_pop_ready", 128'(req1_ready), 128'd1);
    cyc();
    i1++;
    req1_state = S1 + 128'(i1);
    #1;
    chk("credit_full_again", 128'(req1_ready), 128'd0);
    req1_valid = 0; rsp_ready = 1;
    wait_idle("bp_drain");
    chk("bp_sb_empty", 128'(exp_q.size()), 128'd0);

    // Reset with blocks in flight
    req0_valid = 1;
    for (int c = 0; c < 3; c++) begin
      req0_state = S0 + 128'(i0);
      #1;
      chk("pre_rst_ready", 128'(req0_ready), 128'd1);
      i0++;
      cyc();
    end
    req0_valid = 0;
    repeat (10) cyc();
    rst_n = 0;
    #1;
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    repeat (3) cyc();
    rst_n = 1;
    base = rsp_cnt;
    repeat (30) cyc();
    chk("post_rst_no_rsp", 128'(rsp_cnt), 128'(base));
    chk("post_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    req0_valid = 1; req0_state = S0 + 128'(i0); rsp_ready = 0;
    pend = ref_enc(S0 + 128'(i0), K0);
    #1;
    chk("post_rst_ready", 128'(req0_ready), 128'd1);
    cyc();
    req0_valid = 0;
    k = 0;
    while (!rsp_valid && k < 40) begin cyc(); k++; end
    chk("post_rst_rsp", 128'(rsp_valid), 128'd1);
    chk("post_rst_data", rsp_data, pend);
    chk("post_rst_id", 128'(rsp_id), 128'd0);
    rsp_ready = 1;
    wait_idle("post_rst_drain");

    // Lone req1 streams back-to-back until credit runs out
    req1_valid = 1;
    for (int c = 0; c < 4; c++) begin
      req1_state = S1 + 128'(i1);
      #1;
      chk("r1_only_ready", 128'(req1_ready), 128'd1);
      chk("r1_only_r0", 128'(req0_ready), 128'd0);
      i1++;
      cyc();
    end
    req1_state = S1 + 128'(i1);
    #1;
    k = 0;
    while (!req1_ready && k < 60) begin cyc(); k++; end
    chk("r1_fifth_accept", 128'(req1_ready), 128'd1);
    cyc();
    req1_valid = 0;
    wait_idle("final_drain");
    chk("final_sb_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
